// File: rtl/pipe_ctrl.sv
// Y86 PIPE hazard/stall controller with data-memory handshake sequencing and run/halt FSM.
// Latency: pipeline controls and dmem_req are combinational; halted/mem_timeout/stall_cycles are registered.
// Backpressure: an un-acked memory request freezes F/D/E/M and bubbles W until ack, timeout or halt.
`timescale 1ns/1ps
module pipe_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       D_icode,
  input  logic [7:0]       d_srcA,
  input  logic [7:0]       d_srcB,
  input  logic [7:0]       E_icode,
  input  logic [7:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [7:0]       M_icode,
  input  logic [7:0]       W_icode,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_stall,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             W_bubble,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] I_HALT   = 8'h0;
  localparam logic [7:0] I_MRMOVL = 8'h5;
  localparam logic [7:0] I_JXX    = 8'h7;
  localparam logic [7:0] I_RET    = 8'h9;
  localparam logic [7:0] I_POPL   = 8'hB;
  localparam logic [7:0] RNONE    = 8'hF;

  // Wait counter must be able to hold the value TIMEOUT itself.
  localparam int              WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TO_V = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALTED} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_cnt_inc;
  logic            timeout_hit;
  logic            m_memop;
  logic            w_halt;
  logic            mem_hold;
  logic            lu, ret, mis;

  assign m_memop = M_icode inside {8'h4, 8'h5, 8'h8, 8'h9, 8'hA, 8'hB};
  assign w_halt  = (W_icode == I_HALT);

  // Request is withheld during reset so an abandoned access is never re-driven.
  assign dmem_req = !rst && m_memop && (state != S_HALTED) && !w_halt;
  assign mem_hold = dmem_req && !dmem_ack;

  assign lu  = ((E_icode == I_MRMOVL) || (E_icode == I_POPL)) && (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mis = (E_icode == I_JXX) && !e_Cnd;

  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign halted       = (state == S_HALTED);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next state: halt in W wins over any ack; the timeout fires when the wait count would reach TIMEOUT.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      S_RUN: begin
        if (w_halt)        state_nxt = S_HALTED;
        else if (mem_hold) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_halt)                         state_nxt = S_HALTED;
        else if (dmem_ack || !dmem_req)     state_nxt = S_RUN;
        else if (wait_cnt_inc == TO_V) begin
          state_nxt   = S_HALTED;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = S_HALTED;
    endcase
  end

  // Wait counter runs only while in WAIT; zero otherwise so each wait starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt_inc;
    else                      wait_cnt <= '0;
  end

  // Sticky timeout cause flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              mem_timeout <= 1'b0;
    else if (timeout_hit) mem_timeout <= 1'b1;
  end

  // Saturating count of memory-wait stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stall_cycles <= '0;
    else if (mem_hold && !(&stall_cycles))  stall_cycles <= stall_cycles + 1'b1;
  end

  // Pipeline register controls by priority: reset/halted, memory hold, then PIPE hazards.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_stall  = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    if (rst || state == S_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_stall  = 1'b1;
      W_stall  = 1'b1;
    end else if (mem_hold) begin
      // E is held by withholding its bubble; its stall follows D_stall|M_stall upstream.
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = 1'b1;
    end else begin
      F_stall  = lu | ret;
      D_stall  = lu;
      D_bubble = mis | (ret & !lu);
      E_bubble = mis | lu;
      // Keep a younger memory op from committing behind HALT.
      M_bubble = w_halt;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expectations.
// Latency: combinational outputs checked mid-cycle, registered outputs one cycle after the cause.
// Backpressure: memory waits are driven by withholding dmem_ack; every wait is cycle-bounded.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic             e_Cnd, dmem_ack;
  logic             dmem_req, F_stall, D_stall, D_bubble, E_bubble;
  logic             M_stall, M_bubble, W_stall, W_bubble;
  logic             halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  // {dmem_req, F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, W_bubble}
  logic [8:0] ctl;
  assign ctl = {dmem_req, F_stall, D_stall, D_bubble, E_bubble, M_stall, M_bubble, W_stall, W_bubble};

  localparam logic [8:0] C_IDLE = 9'b0_0000_0000;
  localparam logic [8:0] C_RSTH = 9'b0_1101_1010;  // reset / halted
  localparam logic [8:0] C_HOLD = 9'b1_1100_1001;  // memory hold
  localparam logic [8:0] C_LU   = 9'b0_1101_0000;
  localparam logic [8:0] C_RET  = 9'b0_1010_0000;
  localparam logic [8:0] C_MIS  = 9'b0_0011_0000;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .W_icode(W_icode), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_stall(M_stall), .M_bubble(M_bubble), .W_stall(W_stall),
    .W_bubble(W_bubble), .halted(halted), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_icode = 8'h1; d_srcA = 8'hF; d_srcB = 8'hF;
    E_icode = 8'h1; E_dstM = 8'hF; e_Cnd  = 1'b1;
    M_icode = 8'h1; W_icode = 8'h1; dmem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    M_icode = 8'h5;  // memory op present: request must still be gated by reset
    #3;
    chk("rst_ctl", 32'(ctl), 32'(C_RSTH));
    chk("rst_halted", 32'(halted), 0);
    chk("rst_tmo", 32'(mem_timeout), 0);
    chk("rst_cnt", 32'(stall_cycles), 0);
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Load/use via MRMOVL on srcA, then RNONE destination, then POPL on srcB.
    E_icode = 8'h5; E_dstM = 8'h3; d_srcA = 8'h3; #1;
    chk("lu_mrmovl", 32'(ctl), 32'(C_LU));
    E_dstM = 8'hF; #1;
    chk("lu_rnone", 32'(ctl), 32'(C_IDLE));
    E_icode = 8'hB; E_dstM = 8'h2; d_srcA = 8'hF; d_srcB = 8'h2; #1;
    chk("lu_popl", 32'(ctl), 32'(C_LU));
    idle_inputs();

    // ret, mispredict, and load/use combined with ret.
    D_icode = 8'h9; #1;
    chk("ret_d", 32'(ctl), 32'(C_RET));
    D_icode = 8'h1; E_icode = 8'h7; e_Cnd = 1'b0; #1;
    chk("mispredict", 32'(ctl), 32'(C_MIS));
    e_Cnd = 1'b1; #1;
    chk("jxx_taken", 32'(ctl), 32'(C_IDLE));
    D_icode = 8'h9; E_icode = 8'h5; E_dstM = 8'h3; d_srcA = 8'h3; #1;
    chk("lu_and_ret", 32'(ctl), 32'(C_LU));
    idle_inputs();
    step();

    // Memory wait: ack on the fourth request cycle; ret hazard in D is suppressed while held.
    M_icode = 8'h5; D_icode = 8'h9;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      if (i < 3) chk($sformatf("wait_hold%0d", i), 32'(ctl), 32'(C_HOLD));
      else       chk("wait_ack", 32'(ctl), 32'(9'b1_1010_0000));
      step();
    end
    idle_inputs();
    #1;
    chk("wait_cnt3", 32'(stall_cycles), 3);
    chk("wait_nohalt", 32'(halted), 0);

    // Ack in the first M cycle: no stall at all.
    M_icode = 8'h4; dmem_ack = 1'b1; #1;
    chk("fast_ctl", 32'(ctl), 32'(9'b1_0000_0000));
    step();
    idle_inputs();
    #1;
    chk("fast_cnt", 32'(stall_cycles), 3);

    // Timeout: no ack, halted rises at edge TIMEOUT+1.
    M_icode = 8'hA; #1;
    chk("tmo_hold", 32'(ctl), 32'(C_HOLD));
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      step();
      chk($sformatf("tmo_halt_e%0d", k), 32'(halted), 32'(k == TIMEOUT + 1));
    end
    chk("tmo_flag", 32'(mem_timeout), 1);
    chk("tmo_cnt", 32'(stall_cycles), 8);
    chk("tmo_ctl", 32'(ctl), 32'(C_RSTH));
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    #1;
    chk("tmo_late_ack", 32'(halted), 1);
    chk("tmo_late_cnt", 32'(stall_cycles), 8);

    // Asynchronous reset between edges clears everything immediately.
    rst = 1'b1; #1;
    chk("arst_halted", 32'(halted), 0);
    chk("arst_tmo", 32'(mem_timeout), 0);
    chk("arst_cnt", 32'(stall_cycles), 0);
    rst = 1'b0;
    idle_inputs();
    step();

    // Reset mid-WAIT abandons the request; a stray ack afterwards does nothing.
    M_icode = 8'h5;
    step();
    step();
    chk("midwait_cnt", 32'(stall_cycles), 2);
    #2;
    rst = 1'b1; #1;
    chk("midwait_rst_cnt", 32'(stall_cycles), 0);
    chk("midwait_rst_ctl", 32'(ctl), 32'(C_RSTH));
    rst = 1'b0;
    idle_inputs();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    #1;
    chk("midwait_ack_ign", 32'(stall_cycles), 0);
    chk("midwait_ack_halt", 32'(halted), 0);
    // State must be RUN: a fresh wait should survive TIMEOUT edges without halting.
    M_icode = 8'h5;
    for (int k = 0; k < TIMEOUT; k++) step();
    chk("midwait_state_run", 32'(halted), 0);
    dmem_ack = 1'b1; #1;
    step();
    idle_inputs();

    // Halt in W with a memory op in M.
    W_icode = 8'h0; M_icode = 8'h4; #1;
    chk("halt_ctl", 32'(ctl), 32'(9'b0_0000_0100));
    step();
    chk("halt_set", 32'(halted), 1);
    W_icode = 8'h1; M_icode = 8'h5;
    step();
    step();
    chk("halt_stays", 32'(halted), 1);
    chk("halt_ctl_after", 32'(ctl), 32'(C_RSTH));
    rst = 1'b1; #1;
    chk("halt_rst", 32'(halted), 0);
    rst = 1'b0;
    idle_inputs();
    step();

    // Halt beats an ack arriving in the same WAIT cycle.
    M_icode = 8'h5;
    step();
    W_icode = 8'h0; dmem_ack = 1'b1;
    step();
    chk("halt_over_ack", 32'(halted), 1);
    rst = 1'b1; #1;
    rst = 1'b0;
    idle_inputs();
    step();

    // Saturation: six 3-cycle waits total 18 hold cycles, clamped at 15.
    for (int e = 0; e < 6; e++) begin
      M_icode = 8'h5; dmem_ack = 1'b0;
      step(); step(); step();
      dmem_ack = 1'b1;
      step();
      idle_inputs();
      #1;
      if (e == 4) chk("sat_at15", 32'(stall_cycles), 15);
    end
    chk("sat_hold", 32'(stall_cycles), 15);
    chk("sat_nohalt", 32'(halted), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
